// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared sizes and types for the register file
package regfile_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

endpackage

// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - decode/writeback side bus of the register file
interface register_file_if;
  import regfile_pkg::*;

  reg_addr_t rsAddress;
  reg_addr_t rtAddress;
  reg_addr_t writeAddress;
  logic      registerRead;
  logic      registerWrite;
  reg_data_t writeData;
  reg_data_t readValue0;
  reg_data_t readValue1;

  modport master (
    output rsAddress, rtAddress, writeAddress, registerRead, registerWrite, writeData,
    input  readValue0, readValue1
  );

  modport slave (
    input  rsAddress, rtAddress, writeAddress, registerRead, registerWrite, writeData,
    output readValue0, readValue1
  );

endinterface

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - gated combinational read port
// REGFILE_WRITE_BYPASS_EN adds same-cycle forwarding of the pending write.
module regfile_read_port
  import regfile_pkg::*;
(
  output reg_data_t rdata,
`ifdef REGFILE_WRITE_BYPASS_EN
  input  logic      wr_en,
  input  reg_addr_t wr_addr,
  input  reg_data_t wr_data,
`endif
  input  reg_addr_t addr,
  input  logic      en,
  input  reg_data_t regs [NUM_REGS]
);

  always_comb begin
    rdata = '0;
    if (en) begin
      rdata = regs[addr];
`ifdef REGFILE_WRITE_BYPASS_EN
      // Writes to register 0 are dropped, so they must not forward either.
      if (wr_en && (wr_addr != ZERO_REG) && (wr_addr == addr)) begin
        rdata = wr_data;
      end
`endif
    end
  end

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - 32x32 register file, two read ports, one write port
// Optional write-through forwarding under REGFILE_WRITE_BYPASS_EN.
module register_file
  import regfile_pkg::*;
(
  input logic            clk,
  input logic            rst,
  register_file_if.slave bus
);

  reg_data_t regs_q [NUM_REGS];
  reg_data_t regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    // Register 0 is never written, so it keeps its reset value of zero.
    if (bus.registerWrite && (bus.writeAddress != ZERO_REG)) begin
      regs_d[bus.writeAddress] = bus.writeData;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  regfile_read_port u_rs_port (
    .rdata   (bus.readValue0),
`ifdef REGFILE_WRITE_BYPASS_EN
    .wr_en   (bus.registerWrite),
    .wr_addr (bus.writeAddress),
    .wr_data (bus.writeData),
`endif
    .addr    (bus.rsAddress),
    .en      (bus.registerRead),
    .regs    (regs_q)
  );

  regfile_read_port u_rt_port (
    .rdata   (bus.readValue1),
`ifdef REGFILE_WRITE_BYPASS_EN
    .wr_en   (bus.registerWrite),
    .wr_addr (bus.writeAddress),
    .wr_data (bus.writeData),
`endif
    .addr    (bus.rtAddress),
    .en      (bus.registerRead),
    .regs    (regs_q)
  );

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed self-checking bench for register_file
// Expectations follow REGFILE_WRITE_BYPASS_EN when it is defined.
`timescale 1ns/1ps
module tb_register_file;
  import regfile_pkg::*;

  logic clk;
  logic rst;
  int   vec_cnt;
  int   miss_cnt;

  register_file_if bus ();

  register_file u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input reg_data_t obs, input reg_data_t exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input reg_addr_t addr, input reg_data_t data);
    @(negedge clk);
    bus.registerWrite = 1'b1;
    bus.writeAddress  = addr;
    bus.writeData     = data;
    @(posedge clk);
    #1;
    bus.registerWrite = 1'b0;
  endtask

  task automatic read_pair(input reg_addr_t rs, input reg_addr_t rt);
    bus.rsAddress = rs;
    bus.rtAddress = rt;
    #1;
  endtask

  localparam reg_data_t NEG_VAL = 32'hFFF78EDD;
  localparam reg_data_t TOP_VAL = 32'hA5A55A5A;

  reg_data_t exp_fwd;

  initial begin
    vec_cnt            = 0;
    miss_cnt           = 0;
    rst                = 1'b0;
    bus.registerRead   = 1'b1;
    bus.registerWrite  = 1'b0;
    bus.rsAddress      = '0;
    bus.rtAddress      = '0;
    bus.writeAddress   = '0;
    bus.writeData      = '0;

    // Reset: both ports read zero at a spread of addresses
    for (int a = 0; a < 32; a += 8) begin
      read_pair(reg_addr_t'(a), reg_addr_t'(31 - a));
      check("rst_rs", bus.readValue0, 32'd0);
      check("rst_rt", bus.readValue1, 32'd0);
    end

    // Writes are ignored while reset is asserted
    bus.registerWrite = 1'b1;
    bus.writeAddress  = 5'd7;
    bus.writeData     = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    bus.registerWrite = 1'b0;
    read_pair(5'd7, 5'd7);
    check("rst_nowrite", bus.readValue0, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    do_write(5'd12, 32'd1234);
    read_pair(5'd12, 5'd0);
    check("wr12_rs", bus.readValue0, 32'd1234);
    check("wr12_rt0", bus.readValue1, 32'd0);

    do_write(5'd0, 32'd1234);
    read_pair(5'd0, 5'd12);
    check("r0_imm", bus.readValue0, 32'd0);
    check("r12_kept", bus.readValue1, 32'd1234);

    do_write(5'd5, NEG_VAL);
    read_pair(5'd5, 5'd12);
    check("neg_rs", bus.readValue0, NEG_VAL);
    check("neg_rt", bus.readValue1, 32'd1234);

    bus.registerRead = 1'b0;
    read_pair(5'd5, 5'd4);
    check("gate_rs", bus.readValue0, 32'd0);
    check("gate_rt", bus.readValue1, 32'd0);
    bus.registerRead = 1'b1;
    #1;
    check("ungate_rs", bus.readValue0, NEG_VAL);
    check("ungate_rt4", bus.readValue1, 32'd0);

    read_pair(5'd5, 5'd5);
    check("same_rs", bus.readValue0, NEG_VAL);
    check("same_rt", bus.readValue1, NEG_VAL);

    do_write(5'd31, TOP_VAL);
    read_pair(5'd31, 5'd30);
    check("r31_rs", bus.readValue0, TOP_VAL);
    check("r30_rt", bus.readValue1, 32'd0);

    // Read of the address being written, before and after the edge
`ifdef REGFILE_WRITE_BYPASS_EN
    exp_fwd = 32'd99;
`else
    exp_fwd = 32'd1234;
`endif
    @(negedge clk);
    bus.registerWrite = 1'b1;
    bus.writeAddress  = 5'd12;
    bus.writeData     = 32'd99;
    read_pair(5'd12, 5'd5);
    check("pre_edge_rs", bus.readValue0, exp_fwd);
    check("pre_edge_rt", bus.readValue1, NEG_VAL);
    bus.registerRead = 1'b0;
    #1;
    check("pre_edge_gated", bus.readValue0, 32'd0);
    bus.registerRead = 1'b1;
    @(posedge clk);
    #1;
    bus.registerWrite = 1'b0;
    #1;
    check("post_edge_rs", bus.readValue0, 32'd99);

    // A write aimed at register 0 never forwards
    @(negedge clk);
    bus.registerWrite = 1'b1;
    bus.writeAddress  = 5'd0;
    bus.writeData     = 32'd77;
    read_pair(5'd0, 5'd0);
    check("zero_pre_edge", bus.readValue0, 32'd0);
    @(posedge clk);
    #1;
    bus.registerWrite = 1'b0;
    #1;
    check("zero_post_edge", bus.readValue1, 32'd0);

    // Asynchronous reset pulse between clock edges
    @(negedge clk);
    #1;
    rst = 1'b0;
    read_pair(5'd5, 5'd12);
    check("async_r5", bus.readValue0, 32'd0);
    check("async_r12", bus.readValue1, 32'd0);
    read_pair(5'd31, 5'd31);
    check("async_r31", bus.readValue0, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    read_pair(5'd5, 5'd31);
    check("after_rst_r5", bus.readValue0, 32'd0);
    check("after_rst_r31", bus.readValue1, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
